// File: rtl/controle_cofre_pkg.sv
// Shared types and default constants for the safe controller.
package controle_cofre_pkg;

    localparam int MAX_TENTATIVAS_DEF = 3;
    localparam int T_ABERTO_DEF       = 8;
    localparam int T_BLOQUEIO_DEF     = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        AVALIA    = 2'd1,
        ABERTO    = 2'd2,
        BLOQUEADO = 2'd3
    } estado_t;

    // Comparator flags latched at the attempt edge.
    typedef struct packed {
        logic acerto;
        logic proximo;
        logic erro;
    } tentativa_t;

    typedef enum logic [1:0] {
        RES_ACERTO,
        RES_PROXIMO,
        RES_ERRO,
        RES_INCONSISTENTE
    } resultado_t;

    // Priority acerto > proximo > erro; anything contradictory is its own class
    // (treated as a failure by the FSM).
    function automatic resultado_t classifica(input tentativa_t t);
        if (t.acerto)                 return RES_ACERTO;
        else if (t.proximo && !t.erro) return RES_PROXIMO;
        else if (t.erro && !t.proximo) return RES_ERRO;
        else                           return RES_INCONSISTENTE;
    endfunction

endpackage

// File: rtl/controle_cofre_if.sv
// Attempt/lock bus between the comparator side and the safe controller.
interface controle_cofre_if #(
    parameter int CW = 2
);
    logic          confirmar;
    logic          acerto;
    logic          proximo;
    logic          erro;
    logic          fechar;
    logic          destrava;
    logic          dica;
    logic          falha;
    logic          bloqueado;
    logic [CW-1:0] erros;

    modport master (
        output confirmar, acerto, proximo, erro, fechar,
        input  destrava, dica, falha, bloqueado, erros
    );

    modport slave (
        input  confirmar, acerto, proximo, erro, fechar,
        output destrava, dica, falha, bloqueado, erros
    );
endinterface

// File: rtl/controle_cofre_temporizador.sv
// Loadable down-counter shared by the open and lockout intervals.
module temporizador_cofre #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] cnt;

    // Load has priority; counting stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt <= '0;
        else if (load)              cnt <= value;
        else if (en && cnt != '0)   cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/controle_cofre.sv
// Safe access controller: attempt evaluation, failure count, open/lockout timing.
module controle_cofre
    import controle_cofre_pkg::*;
#(
    parameter int MAX_TENTATIVAS = MAX_TENTATIVAS_DEF,
    parameter int T_ABERTO       = T_ABERTO_DEF,
    parameter int T_BLOQUEIO     = T_BLOQUEIO_DEF,
    parameter int CW             = $clog2(MAX_TENTATIVAS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    controle_cofre_if.slave  bus
);
    localparam int TMAX = (T_ABERTO > T_BLOQUEIO) ? T_ABERTO : T_BLOQUEIO;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    estado_t       estado, estado_d;
    tentativa_t    cap;
    resultado_t    res;
    logic          confirmar_q, borda, cap_en;
    logic          destrava_q, destrava_d;
    logic          dica_q, dica_d;
    logic          falha_q, falha_d;
    logic          bloqueado_q, bloqueado_d;
    logic [CW-1:0] erros_q, erros_d, erros_inc;
    logic          t_load, t_en, t_zero;
    logic [TW-1:0] t_val;

    assign borda     = bus.confirmar && !confirmar_q;
    assign res       = classifica(cap);
    assign erros_inc = erros_q + CW'(1);

    temporizador_cofre #(.W(TW)) u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (t_load),
        .value (t_val),
        .en    (t_en),
        .zero  (t_zero)
    );

    // State, registered outputs, edge-detect history and flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado      <= IDLE;
            confirmar_q <= 1'b0;
            cap         <= '0;
            destrava_q  <= 1'b0;
            dica_q      <= 1'b0;
            falha_q     <= 1'b0;
            bloqueado_q <= 1'b0;
            erros_q     <= '0;
        end else begin
            estado      <= estado_d;
            confirmar_q <= bus.confirmar;
            if (cap_en) cap <= '{acerto: bus.acerto, proximo: bus.proximo, erro: bus.erro};
            destrava_q  <= destrava_d;
            dica_q      <= dica_d;
            falha_q     <= falha_d;
            bloqueado_q <= bloqueado_d;
            erros_q     <= erros_d;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        estado_d    = estado;
        destrava_d  = destrava_q;
        dica_d      = dica_q;
        falha_d     = 1'b0;
        bloqueado_d = bloqueado_q;
        erros_d     = erros_q;
        cap_en      = 1'b0;
        t_load      = 1'b0;
        t_val       = '0;
        t_en        = 1'b0;
        unique case (estado)
            IDLE: begin
                if (borda) begin
                    cap_en   = 1'b1;
                    estado_d = AVALIA;
                end
            end
            AVALIA: begin
                if (res == RES_ACERTO) begin
                    estado_d   = ABERTO;
                    destrava_d = 1'b1;
                    erros_d    = '0;
                    dica_d     = 1'b0;
                    t_load     = 1'b1;
                    t_val      = TW'(T_ABERTO - 1);
                end else begin
                    falha_d = 1'b1;
                    dica_d  = cap.proximo;
                    erros_d = erros_inc;
                    if (erros_inc == CW'(MAX_TENTATIVAS)) begin
                        // Counter sits at the limit during lockout, cleared on exit.
                        estado_d    = BLOQUEADO;
                        bloqueado_d = 1'b1;
                        dica_d      = 1'b0;
                        t_load      = 1'b1;
                        t_val       = TW'(T_BLOQUEIO - 1);
                    end else begin
                        estado_d = IDLE;
                    end
                end
            end
            ABERTO: begin
                if (t_zero || bus.fechar) begin
                    destrava_d = 1'b0;
                    estado_d   = IDLE;
                end else begin
                    t_en = 1'b1;
                end
            end
            BLOQUEADO: begin
                if (t_zero) begin
                    bloqueado_d = 1'b0;
                    erros_d     = '0;
                    estado_d    = IDLE;
                end else begin
                    t_en = 1'b1;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    assign bus.destrava  = destrava_q;
    assign bus.dica      = dica_q;
    assign bus.falha     = falha_q;
    assign bus.bloqueado = bloqueado_q;
    assign bus.erros     = erros_q;
endmodule

// File: tb/tb_controle_cofre.sv
// Directed self-checking bench for controle_cofre.
module tb_controle_cofre;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   pulsos;

    always #5 clk = ~clk;

    controle_cofre_if #(.CW(2)) bus ();

    controle_cofre #(
        .MAX_TENTATIVAS(3),
        .T_ABERTO(8),
        .T_BLOQUEIO(16),
        .CW(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Upstream comparator model: equal / |diff|<=3 / |diff|>3.
    task automatic set_cmp(input int senha, input int tent);
        int d;
        d = (senha > tent) ? senha - tent : tent - senha;
        bus.acerto  = (d == 0);
        bus.proximo = (d <= 3);
        bus.erro    = (d > 3);
    endtask

    // One-cycle confirm pulse; returns at the negedge where results are visible.
    task automatic tentativa();
        bus.confirmar = 1'b1;
        tick(1);
        bus.confirmar = 1'b0;
        tick(1);
    endtask

    initial begin
        bus.confirmar = 1'b0;
        bus.fechar    = 1'b0;
        set_cmp(0, 0);

        // 1: reset
        tick(3);
        chk("rst_destrava",  bus.destrava, 0);
        chk("rst_falha",     bus.falha, 0);
        chk("rst_bloqueado", bus.bloqueado, 0);
        chk("rst_dica",      bus.dica, 0);
        chk("rst_erros",     bus.erros, 0);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_destrava", bus.destrava, 0);

        // 2: correct attempt opens for exactly 8 cycles
        set_cmp(5, 5);
        bus.confirmar = 1'b1;
        tick(1);
        chk("open_lat1", bus.destrava, 0);
        bus.confirmar = 1'b0;
        tick(1);
        for (int i = 0; i < 8; i++) begin
            chk("open_hold", bus.destrava, 1);
            chk("open_nofalha", bus.falha, 0);
            tick(1);
        end
        chk("open_end", bus.destrava, 0);
        chk("open_erros", bus.erros, 0);

        // 3: near miss then success
        set_cmp(5, 7);
        tentativa();
        chk("near_falha", bus.falha, 1);
        chk("near_dica", bus.dica, 1);
        chk("near_erros", bus.erros, 1);
        chk("near_destrava", bus.destrava, 0);
        tick(1);
        chk("near_falha_pulse", bus.falha, 0);
        chk("near_dica_keep", bus.dica, 1);
        set_cmp(5, 5);
        tentativa();
        chk("ok_dica", bus.dica, 0);
        chk("ok_erros", bus.erros, 0);
        chk("ok_destrava", bus.destrava, 1);
        tick(8);
        chk("ok_closed", bus.destrava, 0);

        // 4: three wrong attempts -> lockout, confirms ignored
        set_cmp(5, 12);
        tentativa();
        chk("wrong1_erros", bus.erros, 1);
        chk("wrong1_dica", bus.dica, 0);
        tentativa();
        chk("wrong2_erros", bus.erros, 2);
        tentativa();
        chk("lock_falha", bus.falha, 1);
        chk("lock_on", bus.bloqueado, 1);
        chk("lock_erros", bus.erros, 3);
        for (int k = 1; k < 16; k++) begin
            bus.confirmar = (k < 12) && (k % 4 == 1);
            tick(1);
            chk("lock_hold", bus.bloqueado, 1);
            chk("lock_nofalha", bus.falha, 0);
            chk("lock_erros_hold", bus.erros, 3);
        end
        bus.confirmar = 1'b0;
        tick(1);
        chk("lock_exit", bus.bloqueado, 0);
        chk("lock_exit_erros", bus.erros, 0);
        tick(2);
        chk("lock_exit_nofalha", bus.falha, 0);

        // 5: held confirm gives a single attempt
        pulsos = 0;
        bus.confirmar = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.falha) pulsos++;
        end
        bus.confirmar = 1'b0;
        tick(1);
        chk("hold_pulsos", pulsos, 1);
        chk("hold_erros", bus.erros, 1);
        tentativa();
        tentativa();
        chk("hold_lock", bus.bloqueado, 1);
        pulsos = 0;
        bus.confirmar = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.falha) pulsos++;
        end
        chk("span_pulsos", pulsos, 0);
        chk("span_unlocked", bus.bloqueado, 0);
        chk("span_erros", bus.erros, 0);
        bus.confirmar = 1'b0;
        tick(1);

        // 6: fechar on the 3rd open cycle, then async reset mid-open
        set_cmp(5, 5);
        tentativa();
        chk("f_open", bus.destrava, 1);
        tick(2);
        bus.fechar = 1'b1;
        tick(1);
        chk("f_closed", bus.destrava, 0);
        bus.fechar = 1'b0;
        tick(1);
        chk("f_stays", bus.destrava, 0);
        tentativa();
        chk("r_open", bus.destrava, 1);
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_async_destrava", bus.destrava, 0);
        chk("r_async_erros", bus.erros, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        set_cmp(5, 6);
        tentativa();
        chk("r_idle_falha", bus.falha, 1);
        chk("r_idle_dica", bus.dica, 1);
        chk("r_idle_erros", bus.erros, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/controle_cofre.md
Name: controle_cofre

Overview:
Sequential controller directly downstream of the safe's combinational password comparator. It consumes the comparator's per-attempt flags (correct, near-miss within 3, wrong) when the user confirms an attempt. It then drives the lock actuator, counts failed attempts and enforces a timed lockout. It turns the comparator's steady-state LED outputs into an attempt-based safe-access protocol.

Parameters:
MAX_TENTATIVAS, 3, failed attempts that trigger lockout (≥1)
T_ABERTO, 8, clock cycles the lock stays released
T_BLOQUEIO, 16, clock cycles of lockout
CW, $clog2(MAX_TENTATIVAS+1), width of failure counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
confirmar  input  1  synchronous level from confirm button; one attempt per rising edge
acerto  input  1  comparator "password equal" flag
proximo  input  1  comparator "difference ≤ 3" flag (also high when equal)
erro  input  1  comparator "difference > 3" flag
fechar  input  1  close request while open
destrava  output  1  lock released
dica  output  1  last failed attempt was a near miss
falha  output  1  one-cycle pulse per failed attempt
bloqueado  output  1  lockout active
erros  output  CW  failed attempts since last success/lockout

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0, erros=0, timer=0, confirmar_q=0. Takes effect immediately in any state. Outputs stay 0 until the first clk edge after rst_n=1.
- confirmar_q registers confirmar every cycle in all states. An attempt edge is confirmar=1 && confirmar_q=0.
- IDLE: on an attempt edge, capture acerto/proximo/erro into registers and go to AVALIA.
- AVALIA (1 cycle), decides on the captured flags with priority acerto > proximo > erro:
  - acerto=1: go to ABERTO; destrava=1; timer=T_ABERTO-1; erros=0; dica=0.
  - otherwise, failure:
    - falha=1 for this one cycle.
    - dica=captured proximo.
    - erros+1.
    - If erros+1 == MAX_TENTATIVAS: go to BLOQUEADO; bloqueado=1; timer=T_BLOQUEIO-1; dica=0.
    - Else go to IDLE.
  - Inconsistent flags (none set, or erro with proximo) with acerto=0 count as failure, with dica=captured proximo.
- Latency: destrava/bloqueado/falha are registered and become visible 2 edges after the edge sampling the attempt.
- ABERTO:
  - Timer decrements each cycle.
  - On timer==0 or fechar=1 (either or both): destrava=0, go to IDLE next edge.
  - Attempt edges are ignored.
  - destrava is high for exactly T_ABERTO cycles absent fechar.
- BLOQUEADO:
  - Timer decrements each cycle; attempt edges are ignored.
  - On timer==0: bloqueado=0, erros=0, go to IDLE.
  - confirmar held high across lockout exit does not create an attempt; a new 0→1 transition is required.
- dica persists until the next evaluated attempt, success or lockout.
- erros saturates logically at MAX_TENTATIVAS because lockout clears it; it never wraps.
- fechar outside ABERTO has no effect.
- Timer width is $clog2(max(T_ABERTO,T_BLOQUEIO)). T=1 gives a single-cycle open/lock.

Decomposition:
- Package controle_cofre_pkg: state enum {IDLE, AVALIA, ABERTO, BLOQUEADO}; default parameter constants.
- One sub-module, temporizador_cofre:
  - Loadable down-counter with load, value, en and zero outputs; async active-low reset.
  - Used for both the open and lockout intervals.
- The FSM, edge detect and failure counter stay in controle_cofre.

Test Plan:
1. rst_n=0 for 3 cycles, then release -> all outputs 0, erros=0, state IDLE.
2. Comparator fed senha=5, tentativa=5 (acerto=1, proximo=1), confirmar pulse -> destrava=1 two edges later for exactly 8 cycles, then 0; erros=0; falha never asserted.
3. senha=5, tentativa=7 (proximo=1, erro=0), one confirm -> falha pulses 1 cycle, dica=1, erros=1, destrava=0. Next confirm with tentativa=5 -> dica=0, erros=0, destrava=1.
4. Three confirms with tentativa=12, senha=5 (erro=1) -> erros 1, 2, then bloqueado=1 for 16 cycles with erros=0 at exit. Confirm pulses during lockout produce no falha/erros change.
5. confirmar held high for 10 cycles in IDLE with wrong attempt -> exactly one falha pulse, erros=1. Same hold spanning lockout exit -> no new attempt.
6. Correct attempt, then fechar=1 on the 3rd open cycle -> destrava drops next edge. Repeat with rst_n=0 mid-ABERTO -> destrava=0 immediately (asynchronous), state IDLE.
